jtag_tap: RTL

JTAG_TAP -- requirements
Module: jtag_tap

---
 rtl/jtag_tap.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/jtag_tap.sv
//------------------------------------------------------------------------------
// jtag_tap : JTAG TAP controller oversampled in the io_clk domain
// Rev 1.0  : IDCODE / USER / BYPASS data registers, 4-bit IR
//------------------------------------------------------------------------------
`default_nettype none

module jtag_tap #(
  parameter logic [31:0] IDCODE = 32'h10002FFF
) (
  input  logic        io_clk,
  input  logic        io_reset,
  input  logic        io_jtag_tck,
  input  logic        io_jtag_tms,
  input  logic        io_jtag_tdi,
  output logic        io_jtag_tdo,
  input  logic [31:0] io_user_capture,
  output logic [31:0] io_user_data,
  output logic        io_user_update,
  output logic [3:0]  io_tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UP_DR  = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UP_IR  = 4'd15
  } tap_state_t;

  localparam logic [3:0] IR_IDCODE = 4'h1;
  localparam logic [3:0] IR_USER   = 4'h2;

  tap_state_t  state_q, state_d;
  logic [2:0]  tck_s_q, tck_s_d;
  logic [1:0]  tms_s_q, tms_s_d;
  logic [1:0]  tdi_s_q, tdi_s_d;
  logic [3:0]  ir_q, ir_d;
  logic [3:0]  ir_sr_q, ir_sr_d;
  logic [31:0] dr_sr_q, dr_sr_d;
  logic        byp_q, byp_d;
  logic        tdo_q, tdo_d;
  logic [31:0] user_data_q, user_data_d;
  logic        update_q, update_d;

  logic tck_rise, tck_fall, tms, tdi, dr_is_32;

  assign tck_s_d  = {tck_s_q[1:0], io_jtag_tck};
  assign tms_s_d  = {tms_s_q[0], io_jtag_tms};
  assign tdi_s_d  = {tdi_s_q[0], io_jtag_tdi};
  assign tck_rise = tck_s_q[1] & ~tck_s_q[2];
  assign tck_fall = ~tck_s_q[1] & tck_s_q[2];
  assign tms      = tms_s_q[1];
  assign tdi      = tdi_s_q[1];
  // Unknown instruction codes fall through to the 1-bit bypass register.
  assign dr_is_32 = (ir_q == IR_IDCODE) || (ir_q == IR_USER);

  always_ff @(posedge io_clk) begin
    if (!io_reset) begin
      state_q     <= TLR;
      tck_s_q     <= '0;
      tms_s_q     <= '0;
      tdi_s_q     <= '0;
      ir_q        <= IR_IDCODE;
      ir_sr_q     <= '0;
      dr_sr_q     <= '0;
      byp_q       <= 1'b0;
      tdo_q       <= 1'b0;
      user_data_q <= '0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tck_s_q     <= tck_s_d;
      tms_s_q     <= tms_s_d;
      tdi_s_q     <= tdi_s_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      dr_sr_q     <= dr_sr_d;
      byp_q       <= byp_d;
      tdo_q       <= tdo_d;
      user_data_q <= user_data_d;
      update_q    <= update_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:     state_d = tms ? TLR    : RTI;
        RTI:     state_d = tms ? SEL_DR : RTI;
        SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms ? UP_DR  : PA_DR;
        PA_DR:   state_d = tms ? EX2_DR : PA_DR;
        EX2_DR:  state_d = tms ? UP_DR  : SH_DR;
        UP_DR:   state_d = tms ? SEL_DR : RTI;
        SEL_IR:  state_d = tms ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms ? UP_IR  : PA_IR;
        PA_IR:   state_d = tms ? EX2_IR : PA_IR;
        EX2_IR:  state_d = tms ? UP_IR  : SH_IR;
        UP_IR:   state_d = tms ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    dr_sr_d     = dr_sr_q;
    byp_d       = byp_q;
    tdo_d       = tdo_q;
    user_data_d = user_data_q;
    update_d    = 1'b0;

    // Capture and shift act on the state being left at the TCK rise.
    if (tck_rise) begin
      case (state_q)
        CAP_IR: ir_sr_d = 4'b0101;
        SH_IR:  ir_sr_d = {tdi, ir_sr_q[3:1]};
        CAP_DR: begin
          if (ir_q == IR_IDCODE)    dr_sr_d = IDCODE;
          else if (ir_q == IR_USER) dr_sr_d = io_user_capture;
          else                      byp_d   = 1'b0;
        end
        SH_DR: begin
          if (dr_is_32) dr_sr_d = {tdi, dr_sr_q[31:1]};
          else          byp_d   = tdi;
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      case (state_q)
        UP_IR: ir_d = ir_sr_q;
        UP_DR: begin
          if (ir_q == IR_USER) begin
            user_data_d = dr_sr_q;
            update_d    = 1'b1;
          end
        end
        default: ;
      endcase
      case (state_q)
        SH_IR:   tdo_d = ir_sr_q[0];
        SH_DR:   tdo_d = dr_is_32 ? dr_sr_q[0] : byp_q;
        default: tdo_d = 1'b0;
      endcase
    end

    if (state_q == TLR) ir_d = IR_IDCODE;
  end

  assign io_jtag_tdo    = tdo_q;
  assign io_user_data   = user_data_q;
  assign io_user_update = update_q;
  assign io_tap_state   = state_q;

endmodule

`default_nettype wire
